// File: rtl/prog_counter_pkg.sv
// rtl/prog_counter_pkg.sv - shared mode codes and one-shot FSM encoding
package prog_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prog_counter_tick_gen.sv
// rtl/prog_counter_tick_gen.sv - prescaler producing one tick every i_prescale+1 enabled cycles
module tick_gen
    import prog_counter_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_sync_clr,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_presc;
    logic                  w_match;

    assign w_match = (r_presc == i_prescale);
    assign o_tick  = i_en && w_match;

    // Prescale counter: restarts on clear/load or after a tick, frozen while disabled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_presc <= '0;
        end else if (i_sync_clr) begin
            r_presc <= '0;
        end else if (i_en) begin
            if (w_match) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - programmable up/down counter with wrap, saturate and one-shot modes
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_load_val,
    input  logic                  i_dir,
    input  logic [1:0]            i_mode,
    input  logic [WIDTH-1:0]      i_limit,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [WIDTH-1:0]      o_out,
    output logic                  o_tc,
    output logic                  o_busy,
    output logic                  o_done
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    // Set once a counting tick found the counter already at terminal; used so
    // saturate mode only reports the first arrival at the terminal value.
    logic             r_parked;
    logic             w_tick;
    logic             w_terminal;
    logic             w_oneshot;
    logic             w_count;

    tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_gen (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_en       (i_en),
        .i_sync_clr (i_clr | i_load),
        .i_prescale (i_prescale),
        .o_tick     (w_tick)
    );

    assign w_terminal = i_dir ? (r_out == '0) : (r_out >= i_limit);
    assign w_oneshot  = (i_mode == MODE_ONESHOT);
    assign w_count    = w_tick && (!w_oneshot || (r_state == ST_RUN));

    // One-shot FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One-shot next state; any non-one-shot mode parks the FSM in IDLE.
    always_comb begin
        w_state_next = r_state;
        if (i_clr || !w_oneshot) begin
            w_state_next = ST_IDLE;
        end else if (i_load) begin
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (w_tick && w_terminal) w_state_next = ST_DONE;
                ST_IDLE: w_state_next = ST_IDLE;
                ST_DONE: w_state_next = ST_DONE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Count register and terminal-count pulse; clear beats load beats tick.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out    <= '0;
            r_tc     <= 1'b0;
            r_parked <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (i_clr) begin
                r_out    <= '0;
                r_parked <= 1'b0;
            end else if (i_load) begin
                r_out    <= i_load_val;
                r_parked <= 1'b0;
            end else if (w_count) begin
                if (!w_terminal) begin
                    r_out    <= i_dir ? (r_out - 1'b1) : (r_out + 1'b1);
                    r_parked <= 1'b0;
                end else begin
                    r_parked <= 1'b1;
                    case (i_mode)
                        MODE_SAT:     r_tc <= !r_parked;
                        MODE_ONESHOT: r_tc <= 1'b1;
                        default: begin
                            r_out <= i_dir ? i_limit : '0;
                            r_tc  <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign o_out  = r_out;
    assign o_tc   = r_tc;
    assign o_busy = (r_state == ST_RUN);
    assign o_done = (r_state == ST_DONE);

endmodule
